conv_window_gen: RTL and testbench

- Streaming 3x3 sliding-window generator that sits directly upstream of arithmetic_core_mod.
- Accepts one raster-order pixel per enabled cycle and emits packed 9-pixel windows (stride 1, no padding) on that core's 72-bit `in` bus, with a matching `en` strobe.
- Two line buffers plus a 3x3 window register let the core receive one window per input pixel once the first two rows are filled.
- Default 10x10 frame produces 64 windows, matching one core run.

---
 rtl/npu_pkg.sv | 19 +
 rtl/conv_window_gen_if.sv | 23 ++
 rtl/npu_line_buffer.sv | 33 +++
 rtl/conv_window_gen.sv | 147 ++++++++++++++
 tb/tb_conv_window_gen.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_pkg.sv
// Shared constants, FSM state encoding and helpers for the NPU streaming front end.
package npu_pkg;

    localparam int DEFAULT_DW = 8;
    localparam int KSZ        = 3;
    localparam int WIN_W      = KSZ * KSZ * DEFAULT_DW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Number of valid 3x3 windows (stride 1, no padding) in a w x h frame.
    function automatic int n_windows(input int w, input int h);
        return (w - 2) * (h - 2);
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle between a raster pixel source and the window generator.
interface conv_window_gen_if #(
    parameter int DW = 8
);

    logic [DW-1:0]   pix_in;
    logic            pix_en;
    logic [9*DW-1:0] win_out;
    logic            win_en;
    logic            frame_done;
    logic            busy;

    modport master (
        output pix_in, pix_en,
        input  win_out, win_en, frame_done, busy
    );

    modport slave (
        input  pix_in, pix_en,
        output win_out, win_en, frame_done, busy
    );

endinterface

// File: rtl/npu_line_buffer.sv
// Shift-register delay line: q is the sample written DEPTH shifts ago.
module npu_line_buffer
    import npu_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          shift_en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [DEPTH];

    // Shift one position per accepted pixel; cleared so stale rows start at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (shift_en) begin
            mem[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign q = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator feeding the arithmetic core's 72-bit bus.
module conv_window_gen
    import npu_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int IMG_W = 10,
    parameter int IMG_H = 10
) (
    input  logic             clk,
    input  logic             reset,
    conv_window_gen_if.slave bus
);

    localparam int NPIX = KSZ * KSZ;
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(KSZ - 1);
    localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(KSZ - 1);
    localparam logic [RW-1:0] ROW_LAST_FILL = RW'(KSZ - 2);

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    state_t            state;
    state_t            state_nxt;
    logic [DW-1:0]     lb0_q;
    logic [DW-1:0]     lb1_q;
    logic [DW-1:0]     win     [NPIX];
    logic [DW-1:0]     win_nxt [NPIX];
    logic [NPIX*DW-1:0] win_packed;
    logic              col_last;
    logic              frame_last;
    logic              win_valid;

    assign col_last   = (col == COL_LAST);
    assign frame_last = col_last && (row == ROW_LAST);
    assign win_valid  = bus.pix_en && (state == RUN)
                        && (row >= ROW_FIRST_WIN) && (col >= COL_FIRST_WIN);

    // lb0 delays the input by one row, lb1 delays lb0 by another row.
    npu_line_buffer #(.DW(DW), .DEPTH(IMG_W)) lb0 (
        .clk      (clk),
        .reset    (reset),
        .shift_en (bus.pix_en),
        .d        (bus.pix_in),
        .q        (lb0_q)
    );

    npu_line_buffer #(.DW(DW), .DEPTH(IMG_W)) lb1 (
        .clk      (clk),
        .reset    (reset),
        .shift_en (bus.pix_en),
        .d        (lb0_q),
        .q        (lb1_q)
    );

    // Raster position of the pixel being accepted; wraps to (0,0) after the frame's last pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (bus.pix_en) begin
            if (col_last) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Frame-progress state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // IDLE until a pixel arrives, FILL while the first two rows load, RUN until the last pixel.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.pix_en) state_nxt = FILL;
            FILL: if (bus.pix_en && col_last && (row == ROW_LAST_FILL)) state_nxt = RUN;
            RUN:  if (bus.pix_en && frame_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next window: every row shifts one column left, the new right column is {lb1, lb0, pixel}.
    always_comb begin
        for (int i = 0; i < NPIX; i++) begin
            win_nxt[i] = win[i];
        end
        for (int rr = 0; rr < KSZ; rr++) begin
            for (int cc = 0; cc < KSZ - 1; cc++) begin
                win_nxt[rr*KSZ + cc] = win[rr*KSZ + cc + 1];
            end
        end
        win_nxt[KSZ-1]   = lb1_q;
        win_nxt[2*KSZ-1] = lb0_q;
        win_nxt[NPIX-1]  = bus.pix_in;
    end

    // Pack the next window with w0 in the MSBs, row-major.
    always_comb begin
        win_packed = '0;
        for (int i = 0; i < NPIX; i++) begin
            win_packed[(NPIX-1-i)*DW +: DW] = win_nxt[i];
        end
    end

    // Window register advances on every accepted pixel, valid or not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NPIX; i++) begin
                win[i] <= '0;
            end
        end else if (bus.pix_en) begin
            for (int i = 0; i < NPIX; i++) begin
                win[i] <= win_nxt[i];
            end
        end
    end

    // Registered core-facing outputs; win_out holds between valid windows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.win_out    <= '0;
            bus.win_en     <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.win_en     <= win_valid;
            bus.frame_done <= win_valid && frame_last;
            if (win_valid) begin
                bus.win_out <= win_packed;
            end
        end
    end

    assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed self-checking bench for conv_window_gen using a 4x4 and a 10x10 instance.
module tb_conv_window_gen;
    import npu_pkg::*;

    logic clk;
    logic reset;

    int n_checks;
    int n_fail;

    conv_window_gen_if #(.DW(8)) bus4 ();
    conv_window_gen_if #(.DW(8)) bus10 ();

    conv_window_gen #(.DW(8), .IMG_W(4), .IMG_H(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    conv_window_gen #(.DW(8), .IMG_W(10), .IMG_H(10)) dut10 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus10.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed windows of a 4x4 frame whose pixel k has value k.
    logic [71:0] exp4 [4];
    initial begin
        exp4[0] = 72'h00_01_02_04_05_06_08_09_0A;
        exp4[1] = 72'h01_02_03_05_06_07_09_0A_0B;
        exp4[2] = 72'h04_05_06_08_09_0A_0C_0D_0E;
        exp4[3] = 72'h05_06_07_09_0A_0B_0D_0E_0F;
    end

    logic [71:0] q4_win [$];
    bit          q4_fd  [$];
    int          fd4_count;
    int          fd4_orphan;
    int          gap4_hits;
    int          busy_drop;

    logic [71:0] q10_win [$];
    bit          q10_fd  [$];
    int          fd10_count;

    // Collect every window of the 4x4 instance shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (bus4.win_en) begin
            q4_win.push_back(bus4.win_out);
            q4_fd.push_back(bus4.frame_done);
        end
        if (bus4.frame_done) begin
            fd4_count++;
            if (!bus4.win_en) fd4_orphan++;
        end
        if (bus4.win_en && !bus4.pix_en) gap4_hits++;
    end

    // Collect every window of the 10x10 instance.
    always @(posedge clk) begin
        #2;
        if (bus10.win_en) begin
            q10_win.push_back(bus10.win_out);
            q10_fd.push_back(bus10.frame_done);
        end
        if (bus10.frame_done) fd10_count++;
    end

    function automatic logic [71:0] add_base(input logic [71:0] w, input logic [7:0] b);
        logic [71:0] o;
        for (int i = 0; i < 9; i++) o[i*8 +: 8] = w[i*8 +: 8] + b;
        return o;
    endfunction

    task automatic clear4();
        q4_win.delete();
        q4_fd.delete();
        fd4_count  = 0;
        fd4_orphan = 0;
        gap4_hits  = 0;
        busy_drop  = 0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive npix pixels base+k into the 4x4 instance with 'gaps' idle cycles after each.
    task automatic drive4(input logic [7:0] base, input int npix, input int gaps, input bit hold);
        for (int k = 0; k < npix; k++) begin
            @(negedge clk);
            bus4.pix_in = 8'(base + k);
            bus4.pix_en = 1'b1;
            for (int g = 0; g < gaps; g++) begin
                @(negedge clk);
                bus4.pix_en = 1'b0;
                if (k < 15 && bus4.busy !== 1'b1) busy_drop++;
            end
        end
        if (!hold) begin
            @(negedge clk);
            bus4.pix_en = 1'b0;
            idle_cycles(3);
        end
    endtask

    task automatic check_frame4(input string tag, input logic [7:0] base, input int first);
        for (int i = 0; i < 4; i++) begin
            if (first + i < q4_win.size()) begin
                n_checks++;
                if (q4_win[first+i] !== add_base(exp4[i], base)) begin
                    n_fail++;
                    $display("[TB] FAIL %s window %0d: got %h expected %h", tag, first + i,
                             q4_win[first+i], add_base(exp4[i], base));
                end
                n_checks++;
                if (q4_fd[first+i] !== (i == 3)) begin
                    n_fail++;
                    $display("[TB] FAIL %s frame_done at window %0d: got %0b expected %0b", tag,
                             first + i, q4_fd[first+i], (i == 3));
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_cycles(2);
        n_checks++;
        if (bus4.win_out !== '0) begin n_fail++; $display("[TB] FAIL reset win_out: got %h expected 0", bus4.win_out); end
        n_checks++;
        if (bus4.win_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset win_en: got %b expected 0", bus4.win_en); end
        n_checks++;
        if (bus4.frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset frame_done: got %b expected 0", bus4.frame_done); end
        n_checks++;
        if (bus4.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset busy: got %b expected 0", bus4.busy); end
        reset = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_continuous();
        clear4();
        drive4(8'h00, 16, 0, 1'b0);
        n_checks++;
        if (q4_win.size() != n_windows(4, 4)) begin
            n_fail++;
            $display("[TB] FAIL continuous count: got %0d expected %0d", q4_win.size(), n_windows(4, 4));
        end
        check_frame4("continuous", 8'h00, 0);
        n_checks++;
        if (fd4_count != 1 || fd4_orphan != 0) begin
            n_fail++;
            $display("[TB] FAIL continuous frame_done pulses: got %0d (orphan %0d) expected 1", fd4_count, fd4_orphan);
        end
    endtask

    task automatic test_gapped();
        clear4();
        drive4(8'h00, 16, 2, 1'b0);
        n_checks++;
        if (q4_win.size() != 4) begin
            n_fail++;
            $display("[TB] FAIL gapped count: got %0d expected 4", q4_win.size());
        end
        check_frame4("gapped", 8'h00, 0);
        n_checks++;
        if (gap4_hits != 0) begin
            n_fail++;
            $display("[TB] FAIL gapped win_en in gap: got %0d expected 0", gap4_hits);
        end
        n_checks++;
        if (busy_drop != 0) begin
            n_fail++;
            $display("[TB] FAIL gapped busy low mid-frame: got %0d expected 0", busy_drop);
        end
        n_checks++;
        if (bus4.busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL gapped busy after frame: got %b expected 0", bus4.busy);
        end
    endtask

    task automatic test_frame10();
        logic [7:0] w0;
        logic [7:0] w8;
        q10_win.delete();
        q10_fd.delete();
        fd10_count = 0;
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                bus10.pix_in = 8'((r * 10 + c) % 256);
                bus10.pix_en = 1'b1;
            end
        end
        @(negedge clk);
        bus10.pix_en = 1'b0;
        idle_cycles(3);
        n_checks++;
        if (q10_win.size() != 64) begin
            n_fail++;
            $display("[TB] FAIL frame10 count: got %0d expected 64", q10_win.size());
        end
        for (int n = 0; n < 64 && n < q10_win.size(); n++) begin
            w0 = q10_win[n][71:64];
            w8 = q10_win[n][7:0];
            n_checks++;
            if (w0 !== 8'((n / 8) * 10 + n % 8)) begin
                n_fail++;
                $display("[TB] FAIL frame10 w0 window %0d: got %h expected %h", n, w0, 8'((n / 8) * 10 + n % 8));
            end
            n_checks++;
            if (w8 !== 8'((n / 8) * 10 + n % 8 + 22)) begin
                n_fail++;
                $display("[TB] FAIL frame10 w8 window %0d: got %h expected %h", n, w8, 8'((n / 8) * 10 + n % 8 + 22));
            end
        end
        n_checks++;
        if (fd10_count != 1 || q10_fd.size() != 64 || q10_fd[63] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL frame10 frame_done: got %0d pulses expected 1 on window 63", fd10_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear4();
        drive4(8'h00, 10, 0, 1'b1);
        @(negedge clk);
        bus4.pix_en = 1'b0;
        reset = 1'b1;
        idle_cycles(2);
        reset = 1'b0;
        idle_cycles(1);
        n_checks++;
        if (q4_win.size() != 0 || fd4_count != 0) begin
            n_fail++;
            $display("[TB] FAIL abort outputs: got %0d windows %0d frame_done expected 0 0", q4_win.size(), fd4_count);
        end
        drive4(8'h80, 16, 0, 1'b0);
        n_checks++;
        if (q4_win.size() != 4) begin
            n_fail++;
            $display("[TB] FAIL after-abort count: got %0d expected 4", q4_win.size());
        end
        n_checks++;
        if (q4_win.size() > 0 && q4_win[0] !== 72'h80_81_82_84_85_86_88_89_8A) begin
            n_fail++;
            $display("[TB] FAIL after-abort first window: got %h expected 808182848586888 98A", q4_win[0]);
        end
        check_frame4("after-abort", 8'h80, 0);
    endtask

    task automatic test_back_to_back();
        clear4();
        drive4(8'h10, 16, 0, 1'b1);
        drive4(8'h60, 16, 0, 1'b0);
        n_checks++;
        if (q4_win.size() != 8) begin
            n_fail++;
            $display("[TB] FAIL back_to_back count: got %0d expected 8", q4_win.size());
        end
        check_frame4("b2b frame1", 8'h10, 0);
        check_frame4("b2b frame2", 8'h60, 4);
        n_checks++;
        if (fd4_count != 2 || fd4_orphan != 0) begin
            n_fail++;
            $display("[TB] FAIL back_to_back frame_done pulses: got %0d expected 2", fd4_count);
        end
    endtask

    task automatic test_reset_held();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus4.win_out !== '0 || bus4.win_en !== 1'b0 || bus4.frame_done !== 1'b0 || bus4.busy !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_held cycle %0d: got out=%h en=%b fd=%b busy=%b expected all 0",
                         k, bus4.win_out, bus4.win_en, bus4.frame_done, bus4.busy);
            end
            bus4.pix_in = 8'(8'hC0 + k);
            bus4.pix_en = 1'b1;
        end
        @(negedge clk);
        bus4.pix_en = 1'b0;
        reset = 1'b0;
        idle_cycles(2);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bus4.pix_in  = '0;
        bus4.pix_en  = 1'b0;
        bus10.pix_in = '0;
        bus10.pix_en = 1'b0;
        fd4_count    = 0;
        fd4_orphan   = 0;
        gap4_hits    = 0;
        busy_drop    = 0;
        fd10_count   = 0;
        $display("[TB] conv_window_gen directed test start");
        test_reset();
        test_continuous();
        test_gapped();
        test_frame10();
        test_reset_mid_frame();
        test_back_to_back();
        test_reset_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
